warp_fetcher: RTL
=================

// Module: warp_fetcher
// PURPOSE
//  Per-core instruction fetcher: the responder to the scheduler's FETCH phase.
//  Watches core_state and the scheduler's warp_select, and returns the instruction at current_pc.
//  Reports progress on fetcher_state, which the scheduler polls for FETCHED.
//  Holds one tagged instruction entry per warp, so a fetch abandoned by a warp switch is not lost.
//  Sits between the scheduler/decoder and the program-memory controller channel.
// PARAMETERS
//  PROGRAM_MEM_ADDR_BITS  8   PC / program address width
//  PROGRAM_MEM_DATA_BITS  16  instruction width
//  NUM_WARPS              2   warps sharing the core; warp id width WARP_BITS = $clog2(NUM_WARPS), min 1
// PORTS
//  clk                     in   1        core clock
//  reset                   in   1        synchronous, active-high
//  core_state              in   3        scheduler state (FETCH=3'b001, DECODE=3'b010)
//  warp_select             in   WARP_BITS warp currently owned by the scheduler
//  current_pc              in   ADDR     PC of the selected warp
//  flush                   in   1        invalidate all warp entries (new kernel / block)
//  mem_read_valid          out  1        program-memory read request
//  mem_read_address        out  ADDR     request address
//  mem_read_ready          in   1        one-cycle response strobe; data valid this cycle
//  mem_read_data           in   DATA     returned instruction
//  fetcher_state           out  3        IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010
//  instruction             out  DATA     instruction for decoder; stable while FETCHED
// BEHAVIOUR
//  Reset: fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0.
//   Reset also clears all entry valid bits and the pending-request record.
//   A response arriving in the reset cycle is dropped. The memory controller shares this reset.
//  IDLE:
//   - core_state==FETCH and entry[warp_select] is valid with tag==current_pc (hit):
//     instruction<=entry data, next state FETCHED. Hit latency is 1 cycle, no memory request.
//   - Miss: mem_read_valid<=1, mem_read_address<=current_pc, record owner=(warp_select,current_pc),
//     next state FETCHING.
//  FETCHING:
//   - mem_read_valid stays 1 and the address stays stable until mem_read_ready. A request is never
//     withdrawn, including on a warp switch or a core_state change.
//   - On mem_read_ready: mem_read_valid<=0 and entry[owner.warp]<={valid,owner.pc,data}.
//     If warp_select==owner.warp and current_pc==owner.pc: instruction<=data, next state FETCHED.
//     Otherwise next state IDLE, which re-runs the lookup for the now-selected warp.
//  FETCHED: holds instruction. Leaves to IDLE when core_state!=FETCH (normally DECODE), so the
//   next FETCH starts a fresh lookup.
//  Flush: clears every valid bit in the same cycle. Flush together with a fill: flush wins and the
//   filled entry stays invalid, but a matching owner still reaches FETCHED with the data.
//   Flush does not cancel an outstanding request.
//  Warp switch while IDLE: lookup uses the new warp_select and current_pc in that cycle.
//  Entries are single-deep per warp; a fill overwrites the owner's previous entry.
//  At most 1 outstanding memory request.
//  PC wraps naturally at 2^ADDR; no special handling.
// STRUCTURE
//  gpu_pkg: core_state_t enum, fetcher_state_t enum (FS_IDLE/FS_FETCHING/FS_FETCHED),
//   and WARP_BITS derivation.
//  Sub-module fetch_entry_array: NUM_WARPS x {valid,tag,data}, one combinational lookup port,
//   one fill port, flush.
//  Top level: 3-state FSM plus the pending-owner register.
// TESTING
//  1 Miss: FETCH, warp0, pc=0x05, mem ready after 3 cycles with 0x3123 ->
//    valid high 3 cycles at addr 0x05, FETCHED with instruction 0x3123.
//  2 Hit: refetch warp0 pc=0x05 after DECODE -> FETCHED 1 cycle after FETCH, mem_read_valid stays 0.
//  3 Warp switch: warp0 pc=0x10 misses, switch to warp1 pc=0x20 before ready, data 0xA0A0 ->
//    entry0 filled, IDLE, then new request at addr 0x20.
//    Switching back to warp0 pc=0x10 hits 0xA0A0.
//  4 Flush: flush in the same cycle as the ready for warp0 pc=0x05 -> FETCHED with the data;
//    the next fetch of 0x05 misses and issues a new request.
//  5 Reset mid-FETCHING: reset asserted while valid high -> next cycle valid=0, state IDLE,
//    all entries invalid; a late ready is ignored.
//  6 Tag mismatch: entry warp1 pc=0x07 valid, fetch warp1 pc=0x08 -> miss, request at addr 0x08.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types for the per-core fetch path: scheduler/fetcher state encodings
// and the warp-id width derivation.
package gpu_pkg;

    typedef enum logic [2:0] {
        CS_IDLE   = 3'b000,
        CS_FETCH  = 3'b001,
        CS_DECODE = 3'b010
    } core_state_t;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'b000,
        FS_FETCHING = 3'b001,
        FS_FETCHED  = 3'b010
    } fetcher_state_t;

    // A single warp still needs a 1-bit select.
    function automatic int unsigned warp_bits(input int unsigned num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

endpackage

// File: rtl/fetch_entry_array.sv
// One tagged instruction entry per warp: combinational lookup, single fill port,
// whole-array flush that takes priority over a same-cycle fill.
module fetch_entry_array
    import gpu_pkg::*;
#(
    parameter int unsigned NUM_WARPS = 2,
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned WARP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [WARP_BITS-1:0] lookup_warp,
    input  logic [ADDR_BITS-1:0] lookup_pc,
    output logic                 lookup_hit,
    output logic [DATA_BITS-1:0] lookup_data,
    input  logic                 fill_en,
    input  logic [WARP_BITS-1:0] fill_warp,
    input  logic [ADDR_BITS-1:0] fill_tag,
    input  logic [DATA_BITS-1:0] fill_data
);

    logic [NUM_WARPS-1:0] valid_q, valid_d;
    logic [ADDR_BITS-1:0] tag_q  [NUM_WARPS];
    logic [ADDR_BITS-1:0] tag_d  [NUM_WARPS];
    logic [DATA_BITS-1:0] data_q [NUM_WARPS];
    logic [DATA_BITS-1:0] data_d [NUM_WARPS];

    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        if (32'(lookup_warp) < NUM_WARPS) begin
            lookup_hit  = valid_q[lookup_warp] && (tag_q[lookup_warp] == lookup_pc);
            lookup_data = data_q[lookup_warp];
        end
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en && (32'(fill_warp) < NUM_WARPS)) begin
            valid_d[fill_warp] = 1'b1;
            tag_d[fill_warp]   = fill_tag;
            data_d[fill_warp]  = fill_data;
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/warp_fetcher.sv
// Per-core instruction fetcher: answers the scheduler's FETCH phase from a per-warp
// entry or a single outstanding program-memory request.
module warp_fetcher
    import gpu_pkg::*;
#(
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
    parameter int unsigned NUM_WARPS             = 2,
    localparam int unsigned WARP_BITS            = warp_bits(NUM_WARPS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [WARP_BITS-1:0]             warp_select,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    fetcher_state_t                   state_q, state_d;
    logic                             valid_q, valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
    logic [WARP_BITS-1:0]             owner_warp_q, owner_warp_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] owner_pc_q, owner_pc_d;

    logic                             hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] hit_data;
    logic                             fill_en;

    fetch_entry_array #(
        .NUM_WARPS (NUM_WARPS),
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .WARP_BITS (WARP_BITS)
    ) u_entries (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .lookup_warp (warp_select),
        .lookup_pc   (current_pc),
        .lookup_hit  (hit),
        .lookup_data (hit_data),
        .fill_en     (fill_en),
        .fill_warp   (owner_warp_q),
        .fill_tag    (owner_pc_q),
        .fill_data   (mem_read_data)
    );

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        owner_warp_d = owner_warp_q;
        owner_pc_d   = owner_pc_q;
        fill_en      = 1'b0;
        unique case (state_q)
            FS_IDLE: begin
                if (core_state == CS_FETCH) begin
                    if (hit) begin
                        instr_d = hit_data;
                        state_d = FS_FETCHED;
                    end else begin
                        valid_d      = 1'b1;
                        addr_d       = current_pc;
                        owner_warp_d = warp_select;
                        owner_pc_d   = current_pc;
                        state_d      = FS_FETCHING;
                    end
                end
            end
            FS_FETCHING: begin
                // The request is held until answered; a switched-away owner still gets its fill.
                if (mem_read_ready) begin
                    valid_d = 1'b0;
                    fill_en = 1'b1;
                    if ((warp_select == owner_warp_q) && (current_pc == owner_pc_q)) begin
                        instr_d = mem_read_data;
                        state_d = FS_FETCHED;
                    end else begin
                        state_d = FS_IDLE;
                    end
                end
            end
            FS_FETCHED: begin
                if (core_state != CS_FETCH) begin
                    state_d = FS_IDLE;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FS_IDLE;
            valid_q      <= 1'b0;
            addr_q       <= '0;
            instr_q      <= '0;
            owner_warp_q <= '0;
            owner_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            owner_warp_q <= owner_warp_d;
            owner_pc_q   <= owner_pc_d;
        end
    end

    assign fetcher_state    = state_q;
    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign instruction      = instr_q;

endmodule
